frame_sync_rx: RTL and testbench
================================

# frame_sync_rx

- Receive end of the frame-sync serial link.
- Oversamples `sclk`, `fsync` and three serial data lines (x/y/z) in the 54 MHz `CLK` domain.
- Deserializes one 14-bit MSB-first word per channel per frame.
- Presents the three words in parallel with a one-cycle valid strobe, for the accelerometer data-capture path.

## Interface
- `DATA_W`, 14: bits per channel per frame.
- `SYNC_STAGES`, 2: synchronizer flops per input (min 2).
- `GUARD_CYC`, 16: `CLK` cycles after a detected fsync rise during which sclk falls are ignored.
- `TIMEOUT_CYC`, 10800: max `CLK` cycles between sclk falls inside a frame (only with `FRAME_RX_TIMEOUT_EN`).
- `CLK` in 1: system clock, 54 MHz. One clock. Reset is asynchronous and active-low.
- `RST` in 1: asynchronous active-low reset.
- `sclk` in 1: serial bit clock, 10 kHz nominal, idles high; asynchronous to `CLK`.
- `fsync` in 1: frame marker, high for one sclk period, launched on an sclk falling edge.
- `x_ser_in`, `y_ser_in`, `z_ser_in` in 1: serial data, launched on sclk rising edges.
- `x_out_data`, `y_out_data`, `z_out_data` out `DATA_W`: last complete received words.
- `data_valid` out 1: one-`CLK` pulse when all three words update.
- `frame_err` out 1: one-`CLK` pulse on an aborted frame.

## Operation
**Link protocol**
- fsync rises on an sclk fall.
- The MSB is launched on the next sclk rise.
- Bits are sampled on sclk falls.
- The sclk fall that ends fsync samples bit DATA_W (MSB); the next DATA_W-1 falls sample down to bit 1.
- Lines are low between frames.

**Input conditioning**
- Every input passes through a SYNC_STAGES chain.
- sclk chain and its delay register reset to 1; all others reset to 0.
- `fall` = delayed & ~synced sclk.
- `frise` = ~delayed & synced fsync.

**FSM**
- IDLE: `fall` ignored. `frise` → ARMED, clear bit counter, load guard counter.
- ARMED: `fall` ignored while the guard counter is non-zero. First `fall` after guard expiry: shift in synchronized x/y/z bits, counter=1 → SHIFT.
- SHIFT: each `fall` shifts all three shift registers left, new bit into LSB, counter+1. On the shift that makes counter==DATA_W → DONE.
- DONE: copy the shift registers to the outputs, pulse `data_valid` → IDLE.

**Boundary cases**
- `frise` in ARMED or SHIFT: pulse `frame_err`, discard partial data, re-enter ARMED with guard reloaded. Outputs keep their previous words.
- `frise` in DONE: DONE completes normally, then the FSM goes to ARMED, not IDLE.
- `frise` and `fall` in the same cycle: `frise` wins; `fall` is ignored (covered by the guard).
- Reset mid-frame: everything returns to the reset state; the partial frame is lost with no error pulse.
- fsync high at reset release counts as a rise.

**Arithmetic**
- Bit counter width is $clog2(DATA_W+1).
- Guard and timeout counters saturate at 0.
- No wrap is visible.

## Timing
- Reset values:
  - outputs: `x/y/z_out_data`=0, `data_valid`=0, `frame_err`=0.
  - internal: state IDLE, counters 0.
- Latency: `data_valid` and the new words appear at the (SYNC_STAGES+2)th `CLK` rising edge after the pin-level sclk fall carrying bit 1 (4 edges at default).
- Outputs are stable from `data_valid` until the next `data_valid`.
- `data_valid` and `frame_err` are never high in the same cycle.
- There is no backpressure; the consumer must take data on `data_valid`.
- Minimum legal sclk half period is 2×(SYNC_STAGES+1) `CLK` cycles. Nominal is 2700.
- GUARD_CYC must be smaller than the sclk half period.

## Configuration
- `FRAME_RX_TIMEOUT_EN` defined:
  - A watchdog reloads to TIMEOUT_CYC on entry to ARMED and on every accepted `fall`.
  - It decrements each cycle in ARMED and SHIFT.
  - On reaching 0: pulse `frame_err`, discard the partial frame → IDLE.
- `FRAME_RX_TIMEOUT_EN` undefined:
  - No watchdog logic.
  - A stalled sclk leaves the FSM in ARMED or SHIFT indefinitely until `frise` or reset.

## Structure
- Package `frame_sync_pkg`:
  - State enum (IDLE, ARMED, SHIFT, DONE).
  - `FRAME_DATA_W`=14 default.
  - Nominal `SCLK_HALF_CYC`=2700.
- Sub-module `frame_sync_sync`:
  - SYNC_STAGES synchronizer with parameterized reset value.
  - Optional delayed output for edge detection.
  - Instantiated five times: sclk and fsync with edge output, three data lines without.

## Test plan
- Nominal frame, x=0x2ABC, y=0x3FFF, z=0x0001 at 10 kHz → single `data_valid`, outputs exactly those values, no `frame_err`.
- Back-to-back frames every 100 sclk periods with x=0x0000 then 0x3FFF → two `data_valid` pulses 540000 `CLK` cycles apart, correct words each time.
- fsync re-asserted after 6 bits, followed by a full frame x=0x1234 → one `frame_err`, then `data_valid` with 0x1234, y/z correct.
- fsync rise skewed 0, +1 and -1 `CLK` relative to its sclk fall → guard prevents a spurious bit; words received correctly in all three cases.
- RST asserted after 9 bits, then a full frame z=0x0F0F → outputs 0 during reset, no `frame_err`, next frame gives 0x0F0F.
- With `FRAME_RX_TIMEOUT_EN`, sclk stopped high after 5 bits → `frame_err` TIMEOUT_CYC cycles after the last fall, FSM in IDLE. Without the macro → no pulse.

Source files
------------

// File: rtl/frame_sync_pkg.sv
// rtl/frame_sync_pkg.sv - shared types and defaults for the frame-sync serial receiver
package frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } frame_state_e;

    localparam int FRAME_DATA_W  = 14;
    localparam int SCLK_HALF_CYC = 2700;

endpackage

// File: rtl/frame_sync_sync.sv
// rtl/frame_sync_sync.sv - multi-flop input synchronizer with optional one-cycle delayed copy
module frame_sync_sync #(
    parameter int   STAGES   = 2,
    parameter logic RST_VAL  = 1'b0,
    parameter bit   EDGE_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic q_dly
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

    generate
        if (EDGE_OUT) begin : g_dly
            logic dly_q;
            logic dly_d;
            always_comb dly_d = q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dly_q <= RST_VAL;
                else        dly_q <= dly_d;
            end
            assign q_dly = dly_q;
        end else begin : g_nodly
            assign q_dly = q;
        end
    endgenerate

endmodule

// File: rtl/frame_sync_rx.sv
// rtl/frame_sync_rx.sv - frame-sync receiver, 3 x DATA_W MSB-first words per frame; FRAME_RX_TIMEOUT_EN adds an sclk watchdog
module frame_sync_rx
    import frame_sync_pkg::*;
#(
    parameter int DATA_W      = FRAME_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 16,
    parameter int TIMEOUT_CYC = 10800
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sclk,
    input  logic              fsync,
    input  logic              x_ser_in,
    input  logic              y_ser_in,
    input  logic              z_ser_in,
    output logic [DATA_W-1:0] x_out_data,
    output logic [DATA_W-1:0] y_out_data,
    output logic [DATA_W-1:0] z_out_data,
    output logic              data_valid,
    output logic              frame_err
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

    logic sclk_s, sclk_dly, fsync_s, fsync_dly;
    logic x_s, y_s, z_s;
    logic x_dly_unused, y_dly_unused, z_dly_unused;

    frame_sync_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_OUT(1'b1)) u_sync_sclk (
        .clk(CLK), .rst_n(RST), .d(sclk), .q(sclk_s), .q_dly(sclk_dly));
    frame_sync_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_OUT(1'b1)) u_sync_fsync (
        .clk(CLK), .rst_n(RST), .d(fsync), .q(fsync_s), .q_dly(fsync_dly));
    frame_sync_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_OUT(1'b0)) u_sync_x (
        .clk(CLK), .rst_n(RST), .d(x_ser_in), .q(x_s), .q_dly(x_dly_unused));
    frame_sync_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_OUT(1'b0)) u_sync_y (
        .clk(CLK), .rst_n(RST), .d(y_ser_in), .q(y_s), .q_dly(y_dly_unused));
    frame_sync_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_OUT(1'b0)) u_sync_z (
        .clk(CLK), .rst_n(RST), .d(z_ser_in), .q(z_s), .q_dly(z_dly_unused));

    logic fall, frise;
    assign fall  = sclk_dly & ~sclk_s;
    assign frise = ~fsync_dly & fsync_s;

    frame_state_e      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [GW-1:0]     guard_q, guard_d;
    logic [DATA_W-1:0] x_sh_q, x_sh_d, y_sh_q, y_sh_d, z_sh_q, z_sh_d;
    logic [DATA_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
    logic              dv_q, dv_d, err_q, err_d;
    logic              arm, take;

`ifdef FRAME_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wdog_q, wdog_d;
`endif

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        guard_d = (guard_q != '0) ? guard_q - GW'(1) : '0;
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        z_sh_d  = z_sh_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        arm     = 1'b0;
        take    = 1'b0;

        case (state_q)
            ST_IDLE:  arm = frise;
            ST_ARMED: begin
                arm   = frise;
                err_d = frise;
                take  = !frise && fall && (guard_q == '0);
            end
            ST_SHIFT: begin
                arm   = frise;
                err_d = frise;
                take  = !frise && fall;
            end
            ST_DONE: begin
                x_out_d = x_sh_q;
                y_out_d = y_sh_q;
                z_out_d = z_sh_q;
                dv_d    = 1'b1;
                arm     = frise;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (take) begin
            x_sh_d  = {x_sh_q[DATA_W-2:0], x_s};
            y_sh_d  = {y_sh_q[DATA_W-2:0], y_s};
            z_sh_d  = {z_sh_q[DATA_W-2:0], z_s};
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == CW'(DATA_W)) ? ST_DONE : ST_SHIFT;
        end

        // A new fsync always restarts the frame; the guard masks the fall it was launched on
        if (arm) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
            guard_d = GW'(GUARD_CYC);
            x_sh_d  = '0;
            y_sh_d  = '0;
            z_sh_d  = '0;
        end

`ifdef FRAME_RX_TIMEOUT_EN
        wdog_d = wdog_q;
        if (arm || take) begin
            wdog_d = TW'(TIMEOUT_CYC);
        end else if (state_q == ST_ARMED || state_q == ST_SHIFT) begin
            wdog_d = (wdog_q != '0) ? wdog_q - TW'(1) : '0;
            if (wdog_q <= TW'(1)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
                x_sh_d  = '0;
                y_sh_d  = '0;
                z_sh_d  = '0;
            end
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            guard_q <= '0;
            x_sh_q  <= '0;
            y_sh_q  <= '0;
            z_sh_q  <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef FRAME_RX_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            z_sh_q  <= z_sh_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            z_out_q <= z_out_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
`ifdef FRAME_RX_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    assign x_out_data = x_out_q;
    assign y_out_data = y_out_q;
    assign z_out_data = z_out_q;
    assign data_valid = dv_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_frame_sync_rx.sv
// tb/tb_frame_sync_rx.sv - directed self-checking bench for frame_sync_rx
module tb_frame_sync_rx;

    localparam int DW  = 14;
    localparam int SS  = 2;
    localparam int GRD = 16;
    localparam int TMO = 300;
    localparam int H   = 20;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          sclk = 1'b1;
    logic          fsync = 1'b0;
    logic          x_ser_in = 1'b0, y_ser_in = 1'b0, z_ser_in = 1'b0;
    logic [DW-1:0] x_out_data, y_out_data, z_out_data;
    logic          data_valid, frame_err;

    frame_sync_rx #(
        .DATA_W(DW), .SYNC_STAGES(SS), .GUARD_CYC(GRD), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .sclk(sclk), .fsync(fsync),
        .x_ser_in(x_ser_in), .y_ser_in(y_ser_in), .z_ser_in(z_ser_in),
        .x_out_data(x_out_data), .y_out_data(y_out_data), .z_out_data(z_out_data),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    always #9 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int dv_cnt = 0, err_cnt = 0, both_cnt = 0, stab_cnt = 0;
    int dv_cyc = 0, prev_dv_cyc = 0, last_fall_cyc = 0;
    logic [DW-1:0] cap_x = '0, cap_y = '0, cap_z = '0;
    logic [DW-1:0] held_x = '0, held_y = '0, held_z = '0;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    always @(negedge CLK) begin
        if (RST) begin
            if (data_valid) begin
                dv_cnt      = dv_cnt + 1;
                prev_dv_cyc = dv_cyc;
                dv_cyc      = cyc_cnt;
                cap_x = x_out_data; cap_y = y_out_data; cap_z = z_out_data;
            end
            if (frame_err) err_cnt = err_cnt + 1;
            if (data_valid && frame_err) both_cnt = both_cnt + 1;
            if (!data_valid && {x_out_data, y_out_data, z_out_data} != {held_x, held_y, held_z})
                stab_cnt = stab_cnt + 1;
        end
        held_x = x_out_data; held_y = y_out_data; held_z = z_out_data;
    end

    initial begin
        #(60000 * 18);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [DW-1:0] xv, input logic [DW-1:0] yv,
                              input logic [DW-1:0] zv, input int nbits, input int skew);
        if (skew < 0) begin
            fsync = 1'b1; cyc(1); sclk = 1'b0; cyc(H - 1);
        end else if (skew > 0) begin
            sclk = 1'b0; cyc(1); fsync = 1'b1; cyc(H - 1);
        end else begin
            sclk = 1'b0; fsync = 1'b1; cyc(H);
        end
        for (int i = DW - 1; i >= DW - nbits; i--) begin
            sclk = 1'b1; x_ser_in = xv[i]; y_ser_in = yv[i]; z_ser_in = zv[i]; cyc(H);
            sclk = 1'b0; fsync = 1'b0; last_fall_cyc = cyc_cnt; cyc(H);
        end
        sclk = 1'b1; fsync = 1'b0; x_ser_in = 1'b0; y_ser_in = 1'b0; z_ser_in = 1'b0;
        cyc(H);
    endtask

    task automatic chk_words(input string tag, input logic [DW-1:0] xv,
                             input logic [DW-1:0] yv, input logic [DW-1:0] zv);
        chk({tag, "_x"}, cap_x, xv);
        chk({tag, "_y"}, cap_y, yv);
        chk({tag, "_z"}, cap_z, zv);
    endtask

    initial begin
        cyc(3);
        chk("rst_x", x_out_data, 0);
        chk("rst_y", y_out_data, 0);
        chk("rst_z", z_out_data, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_err", frame_err, 0);
        RST = 1'b1;
        cyc(10);

        send_frame(14'h2ABC, 14'h3FFF, 14'h0001, DW, 0);
        cyc(10);
        chk("nom_dv_cnt", dv_cnt, 1);
        chk("nom_err_cnt", err_cnt, 0);
        chk_words("nom", 14'h2ABC, 14'h3FFF, 14'h0001);
        chk("nom_latency", dv_cyc - last_fall_cyc, SS + 2);

        send_frame(14'h0000, 14'h155A, 14'h2AA5, DW, 0);
        chk_words("b2b0", 14'h0000, 14'h155A, 14'h2AA5);
        cyc(170 * H);
        send_frame(14'h3FFF, 14'h0AA5, 14'h1FFE, DW, 0);
        chk_words("b2b1", 14'h3FFF, 14'h0AA5, 14'h1FFE);
        chk("b2b_gap", dv_cyc - prev_dv_cyc, 200 * H);
        chk("b2b_dv_cnt", dv_cnt, 3);

        send_frame(14'h3FFF, 14'h3FFF, 14'h3FFF, 6, 0);
        chk("err_partial_no_dv", dv_cnt, 3);
        send_frame(14'h1234, 14'h0567, 14'h3ABC, DW, 0);
        chk("err_cnt", err_cnt, 1);
        chk("err_dv_cnt", dv_cnt, 4);
        chk_words("err_full", 14'h1234, 14'h0567, 14'h3ABC);

        cyc(50);
        send_frame(14'h0F1E, 14'h2D3C, 14'h1B2A, DW, -1);
        chk_words("skew_m1", 14'h0F1E, 14'h2D3C, 14'h1B2A);
        cyc(50);
        send_frame(14'h3C3C, 14'h0303, 14'h2481, DW, 0);
        chk_words("skew_0", 14'h3C3C, 14'h0303, 14'h2481);
        cyc(50);
        send_frame(14'h1555, 14'h2AAA, 14'h3001, DW, 1);
        chk_words("skew_p1", 14'h1555, 14'h2AAA, 14'h3001);
        chk("skew_dv_cnt", dv_cnt, 7);
        chk("skew_err_cnt", err_cnt, 1);

        cyc(50);
        send_frame(14'h3FFF, 14'h3FFF, 14'h3FFF, 9, 0);
        RST = 1'b0;
        cyc(3);
        chk("mrst_x", x_out_data, 0);
        chk("mrst_y", y_out_data, 0);
        chk("mrst_z", z_out_data, 0);
        RST = 1'b1;
        cyc(10);
        send_frame(14'h0111, 14'h2222, 14'h0F0F, DW, 0);
        chk_words("mrst_full", 14'h0111, 14'h2222, 14'h0F0F);
        chk("mrst_err_cnt", err_cnt, 1);
        chk("mrst_dv_cnt", dv_cnt, 8);

        chk("dv_err_overlap", both_cnt, 0);
        chk("out_stability", stab_cnt, 0);

        cyc(50);
        send_frame(14'h3FFF, 14'h3FFF, 14'h3FFF, 5, 0);
        cyc(TMO + 200);
`ifdef FRAME_RX_TIMEOUT_EN
        chk("timeout_err", err_cnt, 2);
`else
        chk("timeout_err", err_cnt, 1);
`endif
        chk("timeout_dv_cnt", dv_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
